// File: rtl/wash_sequencer_pkg.sv
// wash_sequencer_pkg: phase encodings shared by the wash controller and its display logic
package wash_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5
  } phase_e;
  function automatic logic is_timed(phase_e p);
    return p inside {FILL, WASH, RINSE, SPIN};
  endfunction
endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// wash_sequencer_tick_gen: prescaler producing a 1-cycle tick every (BASE << freq) enabled cycles
module wash_sequencer_tick_gen #(
  parameter int BASE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] freq_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o
);
  localparam int PW = $clog2(BASE * 8 + 1);
  logic [1:0]    freq_q;
  logic [PW-1:0] presc_q, presc_d, div;
  assign div     = PW'(BASE) << freq_q;
  assign tick_o  = en_i && presc_q == div - PW'(1);
  assign presc_d = clr_i ? '0 : !en_i ? presc_q : tick_o ? '0 : presc_q + PW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      freq_q  <= '0;
      presc_q <= '0;
    end else begin
      freq_q  <= load_i ? freq_i : freq_q;
      presc_q <= presc_d;
    end
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: coin-operated wash FSM, FILL -> (WASH -> RINSE) x N -> SPIN -> DONE
import wash_sequencer_pkg::*;
module wash_sequencer #(
  parameter int TICK_DIV_BASE = 2,
  parameter int FILL_TICKS    = 2,
  parameter int WASH_TICKS    = 5,
  parameter int RINSE_TICKS   = 2,
  parameter int SPIN_TICKS    = 1,
  parameter int CNT_W         = 9,
  parameter int REP_W         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic [REP_W-1:0] wash_reps,
  input  logic             timer_pause,
  input  logic             abort,
  output logic             wash_done,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] ticks_left,
  output logic [REP_W-1:0] rep_left
);
  phase_e           state_q, state_d, nxt;
  logic [CNT_W-1:0] ticks_q, ticks_d, nxt_dur;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             start, timed, kill, tick;
  assign timed = is_timed(state_q);
  assign kill  = abort && state_q != IDLE;
  assign start = state_q == IDLE && coin_in && !abort;
  wash_sequencer_tick_gen #(.BASE(TICK_DIV_BASE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start),
    .freq_i (clk_freq),
    .en_i   (timed && !kill && !(state_q == SPIN && timer_pause)),
    .clr_i  (!timed || kill),
    .tick_o (tick)
  );
  assign nxt = state_q == FILL ? WASH : state_q == WASH ? RINSE :
               state_q == RINSE ? (rep_q > REP_W'(1) ? WASH : SPIN) : DONE;
  assign nxt_dur = nxt == WASH ? CNT_W'(WASH_TICKS) : nxt == RINSE ? CNT_W'(RINSE_TICKS) :
                   nxt == SPIN ? CNT_W'(SPIN_TICKS) : '0;
  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    rep_d   = rep_q;
    if (kill) begin
      state_d = IDLE;
      ticks_d = '0;
      rep_d   = '0;
    end else if (start) begin
      state_d = FILL;
      ticks_d = CNT_W'(FILL_TICKS);
      rep_d   = wash_reps == '0 ? REP_W'(1) : wash_reps;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      rep_d   = '0;
    end else if (tick && ticks_q != CNT_W'(1)) begin
      ticks_d = ticks_q - CNT_W'(1);
    end else if (tick) begin
      state_d = nxt;
      ticks_d = nxt_dur;
      // a new pass starts only when RINSE loops back to WASH
      rep_d   = (state_q == RINSE && nxt == WASH) ? rep_q - REP_W'(1) : rep_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ticks_q <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      ticks_q <= ticks_d;
      rep_q   <= rep_d;
    end
  assign wash_done  = state_q == DONE;
  assign busy       = timed;
  assign phase      = state_q;
  assign ticks_left = ticks_q;
  assign rep_left   = rep_q;
endmodule
